// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake with a
// variable-latency memory, buffers one word for a stalled decode, squashes on branches.
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WriteEnable,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] IF_Instr,
  output logic [15:0] PC_in,
  output logic        halted
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_areg;
  logic [15:0] r_buf;
  logic [15:0] r_bufpc;
  logic        r_req;
  logic        r_halted;

  logic [15:0] w_bufpc2;
  logic        w_is_hlt;

  assign w_bufpc2 = r_bufpc + 16'd2;
  assign w_is_hlt = (r_buf[15:12] == 4'b1111);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_areg   <= RESET_PC;
      r_buf    <= 16'h0000;
      r_bufpc  <= RESET_PC;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          r_req <= 1'b1;
          if (br_taken) begin
            r_pc <= br_target;
            if (imem_ready) begin
              r_areg <= br_target;
            end else begin
              // The in-flight request cannot be cancelled; wait it out at the old address.
              r_state <= S_DRAIN;
            end
          end else if (imem_ready) begin
            r_buf   <= imem_data;
            r_bufpc <= r_pc;
            r_state <= S_HOLD;
            r_req   <= 1'b0;
          end
        end
        S_HOLD: begin
          if (br_taken) begin
            r_pc    <= br_target;
            r_areg  <= br_target;
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end else if (WriteEnable) begin
            if (w_is_hlt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= w_bufpc2;
              r_areg  <= w_bufpc2;
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (br_taken) begin
            r_pc <= br_target;
          end
          if (imem_ready) begin
            r_areg  <= br_taken ? br_target : r_pc;
            r_state <= S_REQ;
          end
        end
        S_HALT: begin
          // A HLT fetched down a mispredicted path is undone by the resolving branch.
          if (br_taken) begin
            r_halted <= 1'b0;
            r_pc     <= br_target;
            r_areg   <= br_target;
            r_state  <= S_REQ;
            r_req    <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_areg;
  assign halted    = r_halted;
  assign IF_Instr  = (!rst && r_state == S_HOLD) ? r_buf : 16'h0000;
  assign PC_in     = rst ? RESET_PC : ((r_state == S_HOLD) ? w_bufpc2 : r_pc);

endmodule
